mux2_rr_arbiter: RTL and testbench

Registered round-robin arbiter that shares one 2:1 data mux between two requesters and drives a single valid/ready output stream. It owns the mux select, holds a grant for a burst of up to MAX_BURST transfers, and switches between requesters without an idle bubble when both are active. It sits directly in front of the gate-level 2:1 mux datapath and is the only block allowed to drive its select.

---
 rtl/mux2_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux2_rr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin burst arbiter driving the select of a shared 2:1 data mux
// Optional build macro MUX_ARB_FIXED_PRI_EN: requester 0 always wins contention.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t     r_state, w_state_nxt;
    logic       r_ptr, w_ptr_nxt;
    logic       r_sel, w_sel_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_gnt, w_gnt_nxt;

    logic       w_own, w_cur, w_xfer, w_limit, w_release, w_tie;
    logic [1:0] w_cand, w_pick;

    // Returns {valid, index}; tie is the index chosen when both request.
    function automatic logic [1:0] f_pick(input logic [1:0] r, input logic tie);
        case (r)
            2'b01:   f_pick = 2'b10;
            2'b10:   f_pick = 2'b11;
            2'b11:   f_pick = {1'b1, tie};
            default: f_pick = 2'b00;
        endcase
    endfunction

`ifdef MUX_ARB_FIXED_PRI_EN
    assign w_tie = 1'b0;
`else
    assign w_tie = ~r_ptr;
`endif

    assign w_own     = (r_state != S_IDLE);
    assign w_cur     = (r_state == S_GRANT1);
    assign w_xfer    = w_own && req[w_cur] && out_ready;
    assign w_limit   = w_xfer && (r_cnt == LAST_BEAT);
    assign w_release = w_own && (!req[w_cur] || w_limit);

    // Below the limit the owner is masked out; at the limit it stays eligible
    // so a lone requester is regranted without a gap.
    always_comb begin
        w_cand = req;
        if (w_own && !w_limit) begin
            w_cand[w_cur] = 1'b0;
        end
    end

    assign w_pick = f_pick(w_cand, w_tie);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        if (!w_own || w_release) begin
            w_cnt_nxt = 8'd0;
            if (w_pick[1]) begin
                w_state_nxt = w_pick[0] ? S_GRANT1 : S_GRANT0;
                w_sel_nxt   = w_pick[0];
                w_ptr_nxt   = w_pick[0];
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (w_xfer) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_gnt_nxt = 2'b00;
        case (w_state_nxt)
            S_GRANT0: w_gnt_nxt = 2'b01;
            S_GRANT1: w_gnt_nxt = 2'b10;
            default:  w_gnt_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b1;
            r_sel   <= 1'b0;
            r_cnt   <= 8'd0;
            r_gnt   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = w_own;
    assign out_valid = w_own && req[r_sel];
    assign out_data  = r_sel ? din1 : din0;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - self-checking bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req;
    logic [WIDTH-1:0] din0, din1;
    logic [1:0]       gnt;
    logic             sel, out_valid, busy, out_ready;
    logic [WIDTH-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;
    bit done  = 1'b0;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din0(din0), .din1(din1),
        .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: owner of the mux (-1 = nobody) and beats moved in the current burst.
    int m_owner = -1;
    int m_last  = 1;
    int m_sel   = 0;
    int m_beats = 0;
    bit m_init  = 1'b0;

    function automatic int m_pick(input logic [1:0] r, input int last);
        if (r == 2'b00) return -1;
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef MUX_ARB_FIXED_PRI_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    always @(posedge clk) begin
        int w;
        bit at_limit;
        logic [1:0] cand;
        if (!rst_n) begin
            m_owner = -1; m_last = 1; m_sel = 0; m_beats = 0; m_init = 1'b1;
        end else if (m_owner < 0) begin
            w = m_pick(req, m_last);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_last = w; m_beats = 0;
            end
        end else begin
            at_limit = 1'b0;
            if (req[m_owner] && out_ready) begin
                m_beats++;
                at_limit = (m_beats == MAX_BURST);
            end
            if (!req[m_owner] || at_limit) begin
                cand = req;
                if (!at_limit) cand[m_owner] = 1'b0;
                w = m_pick(cand, m_last);
                if (w < 0) begin
                    m_owner = -1;
                end else begin
                    m_owner = w; m_sel = w; m_last = w;
                end
                m_beats = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init && !done) begin
            chk("gnt",       int'(gnt),       (m_owner < 0) ? 0 : (1 << m_owner));
            chk("sel",       int'(sel),       m_sel);
            chk("busy",      int'(busy),      (m_owner >= 0) ? 1 : 0);
            chk("out_valid", int'(out_valid), (m_owner >= 0 && req[m_owner]) ? 1 : 0);
            chk("out_data",  int'(out_data),  (m_sel != 0) ? int'(din1) : int'(din0));
        end
    end

    task automatic drive(input logic [1:0] r, input logic rdy);
        #1;
        req = r;
        out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b11; out_ready = 1'b1; din0 = 8'h3C; din1 = 8'hA5;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        #1 rst_n = 1'b1;

        // Contention: requester 0 first (ptr=1 after reset), then alternating every 4 beats
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
`ifdef MUX_ARB_FIXED_PRI_EN
            chk("contend_gnt", int'(gnt), 1);
`else
            chk("contend_gnt", int'(gnt), ((k / 4) % 2 == 1) ? 2 : 1);
`endif
            if (k == 0) chk("first_data", int'(out_data), 8'h3C);
        end

        // Single requester 1: keeps the grant across burst boundaries with no gap
        drive(2'b10, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("single_gnt", int'(gnt), 2);
            chk("single_data", int'(out_data), 8'hA5);
        end

        drive(2'b00, 1'b1);
        @(negedge clk);
        chk("idle_gnt", int'(gnt), 0);
        chk("idle_sel", int'(sel), 1);
        chk("idle_busy", int'(busy), 0);

        // Backpressure in GRANT0
        drive(2'b11, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_gnt", int'(gnt), 1);
            chk("stall_valid", int'(out_valid), 1);
        end
        drive(2'b11, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_stall_gnt", int'(gnt), 1);
        end
        @(negedge clk);
`ifdef MUX_ARB_FIXED_PRI_EN
        chk("burst_end_gnt", int'(gnt), 1);
`else
        chk("burst_end_gnt", int'(gnt), 2);
`endif

        // Early release from GRANT1 after two beats
        drive(2'b10, 1'b1);
        repeat (2) @(negedge clk);
        chk("early_gnt", int'(gnt), 2);
        drive(2'b00, 1'b1);
        @(negedge clk);
        chk("early_idle_gnt", int'(gnt), 0);
        chk("early_idle_sel", int'(sel), 1);
        drive(2'b01, 1'b1);
        @(negedge clk);
        chk("regrant0_gnt", int'(gnt), 1);
        chk("regrant0_sel", int'(sel), 0);

        // Mixed request/ready patterns checked by the reference only
        for (int k = 0; k < 48; k++) begin
            #1;
            din0 = 8'(k * 7 + 1);
            din1 = 8'(k * 13 + 2);
            req = (k % 7 == 0) ? 2'b00 : ((k % 3 == 0) ? 2'b01 : ((k % 5 == 1) ? 2'b10 : 2'b11));
            out_ready = (k % 5) != 2;
            @(negedge clk);
        end

        // Reset in the middle of a burst
        drive(2'b11, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sel", int'(sel), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_gnt", int'(gnt), 1);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
